// File: rtl/dac_pkg.sv
// Shared types and conversion helpers for the DAC transmit path.
// Holds the state encoding, midscale and offset-binary conversion.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_UFLOW = 2'd3
  } dac_state_e;

  localparam int UF_CNT_W = 16;

  function automatic logic [31:0] dac_mid(input int out_w);
    return 32'd1 << (out_w - 1);
  endfunction

  // Round half up, shift, saturate, then flip MSB to offset binary.
  function automatic logic [31:0] to_dac(
    input logic signed [63:0] x,
    input int                 in_w,
    input int                 out_w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    int                 sh;
    sh = in_w - out_w;
    r  = x;
    if (sh > 0) r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return (32'(r) ^ dac_mid(out_w)) & ((32'd1 << out_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO with occupancy count and sync flush.
// Combinational read of the head entry.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dac_tx.sv
// DAC transmit path: sample FIFO, prime/run/underflow sequencing.
// Optional underflow_cnt output when DAC_UNDERFLOW_CNT_EN is defined.
module dac_tx
  import dac_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int RATE_DIV     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          valid_in,
  input  logic [INPUT_WIDTH-1:0]        tx_i,
  input  logic [INPUT_WIDTH-1:0]        tx_q,
  output logic                          ready_out,
  output logic [OUTPUT_WIDTH-1:0]       dac_i,
  output logic [OUTPUT_WIDTH-1:0]       dac_q,
  output logic                          dac_valid,
  output logic                          underflow,
  input  logic                          clear_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DAC_UNDERFLOW_CNT_EN
  ,
  output logic [UF_CNT_W-1:0]           underflow_cnt
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int SW = 2 * INPUT_WIDTH;
  localparam logic [OUTPUT_WIDTH-1:0] MID =
    OUTPUT_WIDTH'(dac_mid(OUTPUT_WIDTH));

  dac_state_e               state_q;
  dac_state_e               state_d;
  logic [CW-1:0]            cnt_q;
  logic                     strobe;
  logic                     pop;
  logic                     flush;
  logic                     cnt_clr;
  logic                     uf_entry;
  logic                     full;
  logic                     empty;
  logic [SW-1:0]            head;
  logic [OUTPUT_WIDTH-1:0]  conv_i;
  logic [OUTPUT_WIDTH-1:0]  conv_q;

  sync_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (valid_in),
    .pop   (pop),
    .din   ({tx_i, tx_q}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign ready_out = !full;
  assign strobe    = (state_q != ST_IDLE) && (cnt_q == '0);

  assign conv_i = OUTPUT_WIDTH'(to_dac(
    64'(signed'(head[SW-1:INPUT_WIDTH])),
    INPUT_WIDTH, OUTPUT_WIDTH));
  assign conv_q = OUTPUT_WIDTH'(to_dac(
    64'(signed'(head[INPUT_WIDTH-1:0])),
    INPUT_WIDTH, OUTPUT_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
    uf_entry = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      flush   = (state_q != ST_IDLE);
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          if (fifo_level >= LW'(FIFO_DEPTH / 2)) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (strobe) begin
            if (empty) begin
              state_d  = ST_UFLOW;
              uf_entry = 1'b1;
            end else begin
              pop = 1'b1;
            end
          end
        end
        ST_UFLOW: state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Rate divider free-runs outside IDLE; restarted on RUN entry.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr || state_q == ST_IDLE) cnt_q <= '0;
    else if (cnt_q == CW'(RATE_DIV - 1))      cnt_q <= '0;
    else                                      cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_i     <= MID;
      dac_q     <= MID;
      dac_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        pop: begin
          dac_i     <= conv_i;
          dac_q     <= conv_q;
          dac_valid <= 1'b1;
        end
        (state_d != ST_RUN): begin
          dac_i     <= MID;
          dac_q     <= MID;
          dac_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               underflow <= 1'b0;
    else if (uf_entry)     underflow <= 1'b1;
    else if (clear_status) underflow <= 1'b0;
  end

`ifdef DAC_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (uf_entry) begin
      if (underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + UF_CNT_W'(1);
    end else if (clear_status) begin
      underflow_cnt <= '0;
    end
  end
`else
  // Underflow events are reported only through the sticky flag.
`endif

endmodule

// File: tb/tb_dac_tx.sv
// Self-checking bench for dac_tx with a queue-based reference model.
// Directed vectors plus a deterministic traffic pattern.
module tb_dac_tx;

  localparam int IW    = 16;
  localparam int OW    = 12;
  localparam int DEPTH = 8;
  localparam int RATE  = 4;
  localparam int SH    = IW - OW;
  localparam logic [OW-1:0] MID = 12'h800;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          valid_in;
  logic [IW-1:0] tx_i;
  logic [IW-1:0] tx_q;
  logic          ready_out;
  logic [OW-1:0] dac_i;
  logic [OW-1:0] dac_q;
  logic          dac_valid;
  logic          underflow;
  logic          clear_status;
  logic [3:0]    fifo_level;
`ifdef DAC_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dac_tx #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .FIFO_DEPTH   (DEPTH),
    .RATE_DIV     (RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .valid_in     (valid_in),
    .tx_i         (tx_i),
    .tx_q         (tx_q),
    .ready_out    (ready_out),
    .dac_i        (dac_i),
    .dac_q        (dac_q),
    .dac_valid    (dac_valid),
    .underflow    (underflow),
    .clear_status (clear_status),
    .fifo_level   (fifo_level)
`ifdef DAC_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Round half up, floor-divide, clamp, then bias to offset binary.
  function automatic logic [OW-1:0] exp_conv(input logic [IW-1:0] s);
    int v;
    v = int'($signed(s));
    v = (v + (1 << (SH - 1))) >>> SH;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return OW'(v + 2048);
  endfunction

  typedef enum {M_IDLE, M_PRIME, M_RUN, M_UF} mmode_e;

  mmode_e        m_mode;
  logic [31:0]   m_fifo[$];
  int            m_t;
  logic [OW-1:0] m_i;
  logic [OW-1:0] m_qd;
  logic          m_v;
  logic          m_uf;
  int            m_cnt;

  always @(posedge clk) begin : model
    bit          can_push;
    bit          uf_set;
    logic [31:0] s;
    if (rst) begin
      m_mode = M_IDLE;
      m_fifo.delete();
      m_t   = 0;
      m_i   = MID;
      m_qd  = MID;
      m_v   = 1'b0;
      m_uf  = 1'b0;
      m_cnt = 0;
    end else begin
      can_push = valid_in && (m_fifo.size() < DEPTH);
      uf_set   = 1'b0;
      if (!enable) begin
        if (m_mode != M_IDLE) m_fifo.delete();
        else if (can_push) m_fifo.push_back({tx_i, tx_q});
        m_mode = M_IDLE;
        m_i = MID; m_qd = MID; m_v = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: m_mode = M_PRIME;
          M_PRIME: begin
            if (m_fifo.size() >= DEPTH / 2) begin
              m_mode = M_RUN;
              m_t    = 0;
            end
          end
          M_RUN: begin
            if (m_t % RATE == 0) begin
              if (m_fifo.size() == 0) begin
                m_mode = M_UF;
                uf_set = 1'b1;
                m_i = MID; m_qd = MID; m_v = 1'b0;
              end else begin
                s    = m_fifo.pop_front();
                m_i  = exp_conv(s[31:16]);
                m_qd = exp_conv(s[15:0]);
                m_v  = 1'b1;
              end
            end
            m_t++;
          end
          default: m_mode = M_PRIME;
        endcase
        if (can_push) m_fifo.push_back({tx_i, tx_q});
      end
      if (uf_set) begin
        m_uf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else if (clear_status) begin
        m_uf  = 1'b0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs",
          {dac_i, dac_q, dac_valid, underflow, ready_out, fifo_level},
          {m_i, m_qd, m_v, m_uf, m_fifo.size() < DEPTH,
           4'(m_fifo.size())});
`ifdef DAC_UNDERFLOW_CNT_EN
      chk("uf_cnt", underflow_cnt, m_cnt);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [IW-1:0] vi [4] = '{16'h7FF8, 16'h0008, 16'h8000, 16'h0000};
  logic [IW-1:0] vq [4] = '{16'h0000, 16'h8000, 16'h0008, 16'h7FF8};
  logic [OW-1:0] ei [4] = '{12'hFFF, 12'h801, 12'h000, 12'h800};
  logic [OW-1:0] eq [4] = '{12'h800, 12'h000, 12'h801, 12'hFFF};

  initial begin
    rst = 1'b1; enable = 1'b0; valid_in = 1'b0;
    tx_i = '0; tx_q = '0; clear_status = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_level", fifo_level, 0);
    chk("rst_dac", {dac_i, dac_q, dac_valid, underflow}, {MID, MID, 2'b00});
    rst = 1'b0;
    tick();
    chk("ready_after_rst", ready_out, 1);

    enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1; tx_i = vi[k]; tx_q = vq[k];
      tick();
      if (k < 3) chk("prime_hold", dac_valid, 0);
    end
    valid_in = 1'b0;
    tick();
    chk("run_entry_idle", dac_valid, 0);
    tick();
    chk("first_valid", {dac_valid, dac_i, dac_q}, {1'b1, ei[0], eq[0]});
    for (int k = 1; k < 4; k++) begin
      tick(3);
      chk("hold_word", {dac_valid, dac_i, dac_q}, {1'b1, ei[k-1], eq[k-1]});
      tick();
      chk("conv_word", {dac_valid, dac_i, dac_q}, {1'b1, ei[k], eq[k]});
    end
    tick(4);
    chk("underflow_set", {underflow, dac_valid, dac_i}, {2'b10, MID});
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("underflow_clr", underflow, 0);
`ifdef DAC_UNDERFLOW_CNT_EN
    chk("uf_cnt_one", underflow_cnt, 1);
`endif

    enable = 1'b0; valid_in = 1'b1;
    tx_i = 16'h1234; tx_q = 16'hEDCB;
    tick(10);
    valid_in = 1'b0;
    chk("bp_level", fifo_level, 8);
    chk("bp_ready", ready_out, 0);

    enable = 1'b1;
    tick(8);
    chk("run_valid", dac_valid, 1);
    enable = 1'b0;
    tick();
    chk("dis_level", fifo_level, 0);
    chk("dis_dac", {dac_i, dac_valid}, {MID, 1'b0});

    enable = 1'b1; valid_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tx_i = 16'(k * 3001); tx_q = 16'(k * 777 + 5);
      tick();
    end
    chk("pre_rst_valid", dac_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_out", {dac_i, dac_q, dac_valid, underflow, ready_out},
        {MID, MID, 3'b001});

    for (int i = 0; i < 300; i++) begin
      valid_in = (i < 150) ? (i % 8 == 0) : (i % 3 != 0);
      tx_i = 16'(i * 2477 + 123);
      if (i % 11 == 0) tx_i = 16'h7FFF;
      if (i % 13 == 0) tx_i = 16'h8000;
      tx_q = ~tx_i;
      clear_status = (i % 50 == 25);
      enable = !(i == 200 || i == 201);
      tick();
    end
    valid_in = 1'b0; clear_status = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
DAC_TX -- requirements
Module: dac_tx

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16: width of two's-complement upstream I/Q samples.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 12: DAC word width; INPUT_WIDTH >= OUTPUT_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO depth; power of 2, >= 4.
REQ-004 SHALL have parameter RATE_DIV, default 4: clk cycles per DAC sample; >= 1.
REQ-005 SHALL have port clk  in  1  the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port enable  in  1  run request for the transmit path.
REQ-008 SHALL have port valid_in  in  1  upstream sample valid.
REQ-009 SHALL have port tx_i  in  INPUT_WIDTH  upstream I sample.
REQ-010 SHALL have port tx_q  in  INPUT_WIDTH  upstream Q sample.
REQ-011 SHALL have port ready_out  out  1  FIFO can accept a sample.
REQ-012 SHALL have port dac_i  out  OUTPUT_WIDTH  offset-binary I word to the DAC.
REQ-013 SHALL have port dac_q  out  OUTPUT_WIDTH  offset-binary Q word to the DAC.
REQ-014 SHALL have port dac_valid  out  1  dac_i/dac_q carry a real sample.
REQ-015 SHALL have port underflow  out  1  sticky underflow flag.
REQ-016 SHALL have port clear_status  in  1  clears the sticky status.
REQ-017 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-018 SHALL push {tx_i,tx_q} when valid_in && ready_out; ready_out = !full; pushes are accepted in any state.
REQ-019 SHALL run a strobe counter 0..RATE_DIV-1 while state != IDLE, strobe at count 0; RATE_DIV=1 strobes every cycle.
REQ-020 SHALL implement states IDLE, PRIME, RUN, UNDERFLOW.
REQ-021 IDLE: dac_* = midscale (2^(OUTPUT_WIDTH-1)), dac_valid=0; enable=1 -> PRIME.
REQ-022 PRIME: outputs held at midscale; fifo_level >= FIFO_DEPTH/2 -> RUN, strobe counter restarted at 0.
REQ-023 RUN: on a strobe with FIFO non-empty, pop one sample; dac_i/dac_q/dac_valid are registered, updating on the cycle after the pop; dac_valid=1 and the word is held between strobes.
REQ-024 RUN: on a strobe with FIFO empty -> UNDERFLOW; a push in the same cycle does not prevent the underflow.
REQ-025 UNDERFLOW: lasts one cycle; underflow set; dac_* = midscale and dac_valid=0 from the next cycle; then -> PRIME.
REQ-026 enable 1->0 in any state: -> IDLE next cycle, FIFO flushed in the same cycle, outputs midscale.
REQ-027 Conversion: add 2^(INPUT_WIDTH-OUTPUT_WIDTH-1) (round half up), arithmetic shift right by INPUT_WIDTH-OUTPUT_WIDTH, saturate to the signed OUTPUT_WIDTH range, invert MSB (offset binary); pure passthrough + MSB invert when widths are equal.
REQ-028 underflow is cleared by clear_status; a simultaneous set takes priority.

Reset
REQ-029 rst: state=IDLE, FIFO empty, fifo_level=0, strobe counter=0, dac_i=dac_q=midscale, dac_valid=0, underflow=0; the same values apply when rst is asserted mid-RUN.
REQ-030 ready_out SHALL be 1 in the first cycle after rst is released.

Configuration
REQ-031 With DAC_UNDERFLOW_CNT_EN defined: output underflow_cnt[15:0]; increments per UNDERFLOW entry, saturates at 16'hFFFF, cleared by clear_status and rst.
REQ-032 Without DAC_UNDERFLOW_CNT_EN: the underflow_cnt port and its logic are absent; all other behaviour is unchanged.

Structure
REQ-033 Shared package dac_pkg: state encodings, midscale and rounding/saturation helper functions.
REQ-034 The FIFO is sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/level, synchronous flush).

Verification (IN=16, OUT=12, DEPTH=8, RATE_DIV=4)
REQ-035 Conversion: tx_i=16'h7FF8 -> dac_i=12'hFFF; 16'h0008 -> 12'h801; 16'h8000 -> 12'h000; 16'h0000 -> 12'h800.
REQ-036 Prime: enable=1, push 3 samples -> dac_valid stays 0; 4th push -> RUN; first dac_valid=1 one cycle after the next strobe; then one new sample every 4 cycles.
REQ-037 Underflow: in RUN stop pushing -> FIFO drains; at the first empty strobe underflow=1, dac=12'h800/dac_valid=0, back to PRIME; clear_status -> underflow=0; underflow_cnt=1 when DAC_UNDERFLOW_CNT_EN is defined.
REQ-038 Backpressure: enable=0, valid_in held 1 for 10 cycles -> 8 samples accepted, ready_out=0, fifo_level=8.
REQ-039 Reset/disable mid-RUN: rst=1 for 1 cycle -> all REQ-029 values next cycle; separately enable 1->0 -> fifo_level=0, dac=12'h800.
